// File: rtl/data_memory.sv
// data_memory: byte-addressable, big-endian data memory for the load/store path.
// Reads are combinational (byte / half-word / word, optional sign extension);
// writes happen on the rising clock edge. Byte indices wrap modulo SIZE, so
// unaligned accesses simply use consecutive bytes from the effective index.
// The storage array `mem` is left unreset so a bench can preload it.
// Optional feature macro: DMEM_ALIGN_CHECK_EN adds a `misaligned` output and
// suppresses misaligned writes.
module data_memory #(
    parameter int SIZE = 16384
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [0:31] addr,
    input  logic [0:31] data_in,
    input  logic        write_enable,
    input  logic        mem_byte,
    input  logic        mem_half_word,
    input  logic        sign_extend,
`ifdef DMEM_ALIGN_CHECK_EN
    output logic        misaligned,
`endif
    output logic [0:31] data_out
);

    localparam int AW = $clog2(SIZE);

    // Storage, MSB-first bytes; index 0 is the lowest address.
    logic [7:0] mem [0:SIZE-1];

    // Effective byte indices; each wraps independently modulo SIZE.
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [AW-1:0] a3;
    logic [7:0]    b0;
    logic [7:0]    b1;
    logic [7:0]    b2;
    logic [7:0]    b3;
    logic          is_byte;
    logic          is_half;
    logic          ext;
    logic          write_ok;

    // High address bits only alias the array; they carry no meaning here.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^addr[0:31-AW];

    assign a0 = addr[32-AW:31];
    assign a1 = a0 + AW'(1);
    assign a2 = a0 + AW'(2);
    assign a3 = a0 + AW'(3);

    assign b0 = mem[a0];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    // Byte size wins over half-word; neither selected means word.
    assign is_byte = mem_byte;
    assign is_half = ~mem_byte & mem_half_word;

    // Sign source is always the most significant byte of the access.
    assign ext = sign_extend & b0[7];

`ifdef DMEM_ALIGN_CHECK_EN
    logic misaligned_raw;
    assign misaligned_raw = (is_half & addr[31]) |
                            (~is_byte & ~is_half & (addr[30:31] != 2'b00));
    assign misaligned     = misaligned_raw & ~reset;
    assign write_ok       = write_enable & ~misaligned_raw;
`else
    assign write_ok       = write_enable;
`endif

    // Combinational load path; forced to zero while reset is held.
    always_comb begin
        data_out = '0;
        if (!reset) begin
            if (is_byte) begin
                data_out = {{24{ext}}, b0};
            end else if (is_half) begin
                data_out = {{16{ext}}, b0, b1};
            end else begin
                data_out = {b0, b1, b2, b3};
            end
        end
    end

    // Store path; reset only gates writes, the array itself keeps its contents.
    always_ff @(posedge clock) begin
        if (!reset && write_ok) begin
            if (is_byte) begin
                mem[a0] <= data_in[24:31];
            end else if (is_half) begin
                mem[a0] <= data_in[16:23];
                mem[a1] <= data_in[24:31];
            end else begin
                mem[a0] <= data_in[0:7];
                mem[a1] <= data_in[8:15];
                mem[a2] <= data_in[16:23];
                mem[a3] <= data_in[24:31];
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: self-checking bench for data_memory. A byte-array reference
// model tracks every store; expected load values are queued when a load is
// driven and compared once the combinational output has settled.
module tb_data_memory;

    localparam int SIZE = 16384;

    // Clock and reset
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic        write_enable;
    logic        mem_byte;
    logic        mem_half_word;
    logic        sign_extend;
    logic [31:0] data_out;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        misaligned;
`endif

    data_memory #(.SIZE(SIZE)) dut (
        .clock         (clock),
        .reset         (reset),
        .addr          (addr),
        .data_in       (data_in),
        .write_enable  (write_enable),
        .mem_byte      (mem_byte),
        .mem_half_word (mem_half_word),
        .sign_extend   (sign_extend),
`ifdef DMEM_ALIGN_CHECK_EN
        .misaligned    (misaligned),
`endif
        .data_out      (data_out)
    );

    // Scoreboard state
    logic [7:0]  ref_mem [0:SIZE-1];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    // Size codes used by the bench: 0 = word, 1 = half-word, 2 = byte.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int idx(input logic [31:0] ad, input int off);
        return (int'(ad[13:0]) + off) % SIZE;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] ad, input int sz, input logic sx);
        logic [7:0] m0, m1, m2, m3;
        m0 = ref_mem[idx(ad, 0)];
        m1 = ref_mem[idx(ad, 1)];
        m2 = ref_mem[idx(ad, 2)];
        m3 = ref_mem[idx(ad, 3)];
        if (sz == 2) return (sx && m0[7]) ? {24'hFFFFFF, m0} : {24'h0, m0};
        if (sz == 1) return (sx && m0[7]) ? {16'hFFFF, m0, m1} : {16'h0, m0, m1};
        return {m0, m1, m2, m3};
    endfunction

    function automatic logic model_misaligned(input logic [31:0] ad, input int sz);
`ifdef DMEM_ALIGN_CHECK_EN
        return (sz == 1 && ad[0]) || (sz == 0 && ad[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_write(input logic [31:0] ad, input logic [31:0] d, input int sz);
        if (sz == 2) begin
            ref_mem[idx(ad, 0)] = d[7:0];
        end else if (sz == 1) begin
            ref_mem[idx(ad, 0)] = d[15:8];
            ref_mem[idx(ad, 1)] = d[7:0];
        end else begin
            ref_mem[idx(ad, 0)] = d[31:24];
            ref_mem[idx(ad, 1)] = d[23:16];
            ref_mem[idx(ad, 2)] = d[15:8];
            ref_mem[idx(ad, 3)] = d[7:0];
        end
    endtask

    task automatic backdoor(input logic [31:0] ad, input logic [7:0] v);
        dut.mem[idx(ad, 0)] = v;
        ref_mem[idx(ad, 0)] = v;
    endtask

    // Driver tasks
    task automatic drive(input logic [31:0] ad, input int sz, input logic sx);
        @(negedge clock);
        addr          = ad;
        mem_byte      = (sz == 2);
        mem_half_word = (sz == 1);
        sign_extend   = sx;
        write_enable  = 1'b0;
        data_in       = '0;
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] e;
        #2;
        if (exp_q.size() == 0) begin
            check({tag, "_empty_q"}, data_out, 32'hxxxx_xxxx);
        end else begin
            e = exp_q.pop_front();
            check(tag, data_out, e);
        end
    endtask

    task automatic read_chk(input string tag, input logic [31:0] ad, input int sz, input logic sx);
        drive(ad, sz, sx);
        exp_q.push_back(reset ? 32'h0 : model_read(ad, sz, sx));
        pop_check(tag);
    endtask

    task automatic read_exp(input string tag, input logic [31:0] ad, input int sz, input logic sx,
                            input logic [31:0] exp);
        drive(ad, sz, sx);
        exp_q.push_back(exp);
        pop_check(tag);
    endtask

    // Store: before the edge the output must still show the old contents.
    task automatic do_write(input string tag, input logic [31:0] ad, input logic [31:0] d,
                            input int sz, input logic rst);
        logic mis;
        drive(ad, sz, 1'b0);
        data_in      = d;
        write_enable = 1'b1;
        reset        = rst;
        mis          = model_misaligned(ad, sz);
        exp_q.push_back(rst ? 32'h0 : model_read(ad, sz, 1'b0));
        pop_check({tag, "_pre"});
`ifdef DMEM_ALIGN_CHECK_EN
        check({tag, "_mis"}, {31'b0, misaligned}, {31'b0, mis & ~rst});
`endif
        @(posedge clock);
        #1;
        if (!rst && !mis) model_write(ad, d, sz);
        write_enable = 1'b0;
        reset        = 1'b0;
    endtask

    // Main sequence
    initial begin
        reset         = 1'b1;
        addr          = '0;
        data_in       = '0;
        write_enable  = 1'b0;
        mem_byte      = 1'b0;
        mem_half_word = 1'b0;
        sign_extend   = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            dut.mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end

        // Preload before releasing reset
        backdoor(32'h2000, 8'h00);
        backdoor(32'h2001, 8'h00);
        backdoor(32'h2002, 8'h00);
        backdoor(32'h2003, 8'h2A);
        repeat (2) @(posedge clock);
        read_exp("reset_out", 32'h2000, 0, 1'b0, 32'h0000_0000);
        @(negedge clock);
        reset = 1'b0;

        // Word read of preloaded data, plus aliasing above SIZE
        read_exp("word_2000", 32'h2000, 0, 1'b0, 32'h0000_002A);
        read_exp("alias_6000", 32'h6000, 0, 1'b0, 32'h0000_002A);
        read_exp("alias_high", 32'hFFFF_2000, 0, 1'b1, 32'h0000_002A);

        // Byte read sign / zero extension
        backdoor(32'h2003, 8'h80);
        read_exp("byte_sx1", 32'h2003, 2, 1'b1, 32'hFFFF_FF80);
        read_exp("byte_sx0", 32'h2003, 2, 1'b0, 32'h0000_0080);
        read_exp("half_pos_sx1", 32'h2002, 1, 1'b1, 32'h0000_0080);
        read_exp("word_ignores_sx", 32'h2000, 0, 1'b1, 32'h0000_0080);

        // Half-word store leaves neighbours untouched
        backdoor(32'h2006, 8'h77);
        backdoor(32'h2007, 8'h66);
        do_write("half_wr", 32'h2004, 32'h1234_ABCD, 1, 1'b0);
        read_exp("half_b0", 32'h2004, 2, 1'b0, 32'h0000_00AB);
        read_exp("half_b1", 32'h2005, 2, 1'b0, 32'h0000_00CD);
        read_exp("half_nb", 32'h2006, 1, 1'b0, 32'h0000_7766);
        read_exp("half_sx1", 32'h2004, 1, 1'b1, 32'hFFFF_ABCD);
        read_exp("half_sx0", 32'h2004, 1, 1'b0, 32'h0000_ABCD);
        read_exp("word_2004", 32'h2004, 0, 1'b0, 32'hABCD_7766);

        // Byte size has priority over half-word
        @(negedge clock);
        addr          = 32'h2004;
        mem_byte      = 1'b1;
        mem_half_word = 1'b1;
        sign_extend   = 1'b1;
        exp_q.push_back(32'hFFFF_FFAB);
        pop_check("byte_priority");

        // Store under reset is dropped; then it lands
        do_write("word_rst", 32'h2008, 32'hDEAD_BEEF, 0, 1'b1);
        read_exp("word_rst_rd", 32'h2008, 0, 1'b0, 32'h0000_0000);
        do_write("word_wr", 32'h2008, 32'hDEAD_BEEF, 0, 1'b0);
        read_exp("word_wr_rd", 32'h2008, 0, 1'b0, 32'hDEAD_BEEF);
        do_write("byte_wr", 32'h200C, 32'h1122_335C, 2, 1'b0);
        read_exp("byte_wr_rd", 32'h200C, 0, 1'b0, 32'h5C00_0000);

        // Wrap-around at the top of the array
        backdoor(32'h3FFE, 8'h11);
        backdoor(32'h3FFF, 8'h22);
        backdoor(32'h0000, 8'h33);
        backdoor(32'h0001, 8'h44);
        read_exp("wrap_word", 32'h3FFE, 0, 1'b0, 32'h1122_3344);
        read_exp("wrap_half", 32'h3FFF, 1, 1'b1, 32'h0000_2233);
        do_write("wrap_wr", 32'h3FFF, 32'hA1B2_C3D4, 0, 1'b0);
        read_chk("wrap_wr_rd", 32'h3FFF, 0, 1'b0);
        read_chk("wrap_lo_rd", 32'h0000, 0, 1'b0);

`ifdef DMEM_ALIGN_CHECK_EN
        // Misaligned word store must not change anything
        do_write("mis_word", 32'h2002, 32'h0102_0304, 0, 1'b0);
        read_exp("mis_word_rd", 32'h2000, 0, 1'b0, 32'h0000_0080);
        do_write("al_word", 32'h2004, 32'h0506_0708, 0, 1'b0);
        read_exp("al_word_rd", 32'h2004, 0, 1'b0, 32'h0506_0708);
        do_write("mis_half", 32'h2011, 32'h0000_BEEF, 1, 1'b0);
        do_write("mis_rst", 32'h2002, 32'h0102_0304, 0, 1'b1);
`endif

        // Random mix of loads and stores in a small window
        for (int i = 0; i < 80; i++) begin
            logic [31:0] ad;
            int          sz;
            ad = 32'h2000 + 32'($urandom_range(0, 23));
            if ($urandom_range(0, 3) == 0) ad[31:14] = 18'($urandom);
            sz = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) begin
                do_write("rnd_wr", ad, $urandom, sz, 1'b0);
            end else begin
                read_chk("rnd_rd", ad, sz, 1'($urandom_range(0, 1)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
